// File: rtl/synth_panel_pkg.sv
// Shared types and constants for the front-panel event scheduler.
// Holds the FSM state encoding, the inc/dec select bit values and the
// drop counter width used by panel_event_sched.
package synth_panel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic INC_BIT    = 1'b0;
  localparam logic DEC_BIT    = 1'b1;
  localparam int   DROP_CNT_W = 8;

endpackage

// File: rtl/panel_event_sched_if.sv
// Config write bus between the panel scheduler and the synth config sink.
// A write moves when cfg_valid and cfg_ready are both high on a clock edge.
interface panel_event_sched_if #(
  parameter int ADDR_W  = 2,
  parameter int PARAM_W = 8
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [PARAM_W-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after the pointer, wrapping modulo N. Returns one-hot grant, its index
// and whether any request was present.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_anyReq
);

  // Walk the requests starting at the pointer and keep the first hit
  always_comb begin
    logic [IW-1:0] cand;
    o_grant  = '0;
    o_idx    = '0;
    o_anyReq = 1'b0;
    cand     = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(i_ptr) + off) % N);
      if (!o_anyReq && i_req[cand]) begin
        o_anyReq      = 1'b1;
        o_idx         = cand;
        o_grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/panel_event_sched.sv
// Front-panel event scheduler for the FM synth.
// Latches button pulses as pending events, serves them round-robin, steps
// the matching parameter up or down and writes the result over the config bus.
// Optional feature: define PANEL_WRAP_EN to wrap at the limits instead of saturating.
module panel_event_sched
  import synth_panel_pkg::*;
#(
  parameter int N_PARAM    = 4,
  parameter int PARAM_W    = 8,
  parameter int PARAM_MAX  = 127,
  parameter int PARAM_INIT = 0,
  parameter int ADDR_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*N_PARAM-1:0]         i_btn_pulse,
  panel_event_sched_if.master          cfg,
  output logic [N_PARAM*PARAM_W-1:0]   o_params_flat,
  output logic                         o_busy,
  output logic [DROP_CNT_W-1:0]        o_drop_cnt
);

  localparam int N_BTN = 2 * N_PARAM;
  localparam int IDX_W = $clog2(N_BTN);
  localparam int K_W   = IDX_W - 1;
  localparam logic [PARAM_W:0]   MAX_EXT  = (PARAM_W+1)'(PARAM_MAX);
  localparam logic [PARAM_W-1:0] MAX_VAL  = PARAM_W'(PARAM_MAX);
  localparam logic [PARAM_W-1:0] INIT_VAL = PARAM_W'(PARAM_INIT);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_BTN - 1);
`ifdef PANEL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_t               r_state;
  state_t               w_nextState;
  logic [N_BTN-1:0]     r_pending;
  logic [IDX_W-1:0]     r_rrPtr;
  logic [IDX_W-1:0]     r_grantIdx;
  logic [PARAM_W-1:0]   r_params [N_PARAM];
  logic                 r_cfgValid;
  logic [ADDR_W-1:0]    r_cfgAddr;
  logic [PARAM_W-1:0]   r_cfgData;
  logic [DROP_CNT_W-1:0] r_dropCnt;

  logic [N_BTN-1:0]     w_grant;
  logic [IDX_W-1:0]     w_grantIdx;
  logic                 w_anyReq;
  logic                 w_doGrant;
  logic                 w_doWrite;
  logic                 w_doAccept;
  logic [N_BTN-1:0]     w_clear;
  logic [N_BTN-1:0]     w_dropHits;
  logic [DROP_CNT_W:0]  w_dropSum;
  logic [K_W-1:0]       w_k;
  logic [PARAM_W:0]     w_stepExt;
  logic [PARAM_W-1:0]   w_newVal;

  rr_arbiter #(
    .N  (N_BTN),
    .IW (IDX_W)
  ) u_arb (
    .i_req    (r_pending),
    .i_ptr    (r_rrPtr),
    .o_grant  (w_grant),
    .o_idx    (w_grantIdx),
    .o_anyReq (w_anyReq)
  );

  // State register; reset pulls the controller back to IDLE from anywhere
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state decode plus the one-cycle strobes that drive the datapath
  always_comb begin
    w_nextState = r_state;
    w_doGrant   = 1'b0;
    w_doWrite   = 1'b0;
    w_doAccept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_doGrant   = 1'b1;
          w_nextState = CALC;
        end
      end
      CALC: begin
        w_doWrite   = 1'b1;
        w_nextState = SEND;
      end
      SEND: begin
        if (r_cfgValid && cfg.cfg_ready) begin
          w_doAccept  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Pending bookkeeping: a new pulse beats the grant clear, a pulse on a
  // bit that stays pending is counted as a drop (saturating)
  always_comb begin
    w_clear    = w_doGrant ? w_grant : '0;
    w_dropHits = i_btn_pulse & r_pending & ~w_clear;
    w_dropSum  = {1'b0, r_dropCnt} + (DROP_CNT_W+1)'($countones(w_dropHits));
  end

  // Step the granted parameter one unit, one bit wider so both limits show up
  always_comb begin
    w_k       = r_grantIdx[IDX_W-1:1];
    w_stepExt = {1'b0, r_params[w_k]};
    w_newVal  = r_params[w_k];
    case (r_grantIdx[0])
      INC_BIT: begin
        w_stepExt = {1'b0, r_params[w_k]} + 1'b1;
        if (w_stepExt > MAX_EXT) w_newVal = WRAP_EN ? '0 : MAX_VAL;
        else                     w_newVal = w_stepExt[PARAM_W-1:0];
      end
      DEC_BIT: begin
        w_stepExt = {1'b0, r_params[w_k]} - 1'b1;
        if (w_stepExt[PARAM_W]) w_newVal = WRAP_EN ? MAX_VAL : '0;
        else                    w_newVal = w_stepExt[PARAM_W-1:0];
      end
    endcase
  end

  // Datapath registers: pending set, pointer, table, config bus, drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_rrPtr    <= '0;
      r_grantIdx <= '0;
      r_cfgValid <= 1'b0;
      r_cfgAddr  <= '0;
      r_cfgData  <= '0;
      r_dropCnt  <= '0;
      for (int i = 0; i < N_PARAM; i++) r_params[i] <= INIT_VAL;
    end else begin
      r_pending <= (r_pending & ~w_clear) | i_btn_pulse;
      r_dropCnt <= w_dropSum[DROP_CNT_W] ? '1 : w_dropSum[DROP_CNT_W-1:0];
      if (w_doGrant) begin
        r_grantIdx <= w_grantIdx;
        r_rrPtr    <= (w_grantIdx == LAST_IDX) ? '0 : w_grantIdx + 1'b1;
      end
      if (w_doWrite) begin
        r_params[w_k] <= w_newVal;
        r_cfgValid    <= 1'b1;
        r_cfgAddr     <= ADDR_W'(w_k);
        r_cfgData     <= w_newVal;
      end
      if (w_doAccept) r_cfgValid <= 1'b0;
    end
  end

  assign cfg.cfg_valid = r_cfgValid;
  assign cfg.cfg_addr  = r_cfgAddr;
  assign cfg.cfg_data  = r_cfgData;
  assign o_busy        = (r_state != IDLE);
  assign o_drop_cnt    = r_dropCnt;

  for (genvar g = 0; g < N_PARAM; g++) begin : gFlat
    assign o_params_flat[g*PARAM_W +: PARAM_W] = r_params[g];
  end

endmodule

// File: tb/tb_panel_event_sched.sv
// Self-checking bench for panel_event_sched.
// A transaction-level model of the scheduler runs alongside the DUT and is
// compared every cycle; directed scenarios add hand-computed expectations.
module tb_panel_event_sched;

  localparam int N_PARAM    = 4;
  localparam int PARAM_W    = 8;
  localparam int PARAM_MAX  = 127;
  localparam int PARAM_INIT = 0;
  localparam int N_BTN      = 2 * N_PARAM;
`ifdef PANEL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy   = 1'b0;
  logic [7:0]  btn   = '0;
  logic [31:0] paramsFlat;
  logic        busy;
  logic [7:0]  dropCnt;

  int total = 0;
  int bad   = 0;

  bit [7:0] mPend;
  int       mPtr, mPhase, mGrant, mDrop, mAddr, mData;
  bit       mValid;
  int       mParams [N_PARAM];

  panel_event_sched_if #(.ADDR_W(2), .PARAM_W(PARAM_W)) cfgIf ();
  assign cfgIf.cfg_ready = rdy;

  panel_event_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_btn_pulse   (btn),
    .cfg           (cfgIf),
    .o_params_flat (paramsFlat),
    .o_busy        (busy),
    .o_drop_cnt    (dropCnt)
  );

  always #5 clk = ~clk;

  // Expected value of one step applied to a parameter
  function automatic int stepValue(input int v, input bit isDec);
    if (!isDec) begin
      if (v == PARAM_MAX) return WRAP ? 0 : PARAM_MAX;
      return v + 1;
    end
    if (v == 0) return WRAP ? PARAM_MAX : 0;
    return v - 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge
  task automatic modelStep(input logic [7:0] b, input logic r, input logic rn);
    int g;
    int k;
    if (!rn) begin
      mPend = '0; mPtr = 0; mPhase = 0; mGrant = 0; mDrop = 0;
      mValid = 1'b0; mAddr = 0; mData = 0;
      for (int i = 0; i < N_PARAM; i++) mParams[i] = PARAM_INIT;
      return;
    end
    g = -1;
    if (mPhase == 0)
      for (int off = 0; off < N_BTN; off++)
        if (g < 0 && mPend[(mPtr + off) % N_BTN]) g = (mPtr + off) % N_BTN;
    for (int i = 0; i < N_BTN; i++)
      if (b[i] && mPend[i] && i != g && mDrop < 255) mDrop++;
    case (mPhase)
      0: if (g >= 0) begin
        mPend[g] = 1'b0;
        mPtr     = (g + 1) % N_BTN;
        mGrant   = g;
        mPhase   = 1;
      end
      1: begin
        k = mGrant / 2;
        mParams[k] = stepValue(mParams[k], (mGrant % 2) == 1);
        mValid = 1'b1;
        mAddr  = k;
        mData  = mParams[k];
        mPhase = 2;
      end
      default: if (r) begin
        mValid = 1'b0;
        mPhase = 0;
      end
    endcase
    mPend = mPend | b;
  endtask

  // Cycle-by-cycle comparison of the DUT against the model
  always @(posedge clk) begin
    logic [31:0] pf;
    modelStep(btn, rdy, rst_n);
    #1;
    pf = '0;
    for (int k = 0; k < N_PARAM; k++) pf[k*PARAM_W +: PARAM_W] = PARAM_W'(mParams[k]);
    checkOutput("cfg_valid", 32'(cfgIf.cfg_valid), 32'(mValid));
    checkOutput("cfg_addr", 32'(cfgIf.cfg_addr), mAddr);
    checkOutput("cfg_data", 32'(cfgIf.cfg_data), mData);
    checkOutput("busy", 32'(busy), 32'(mPhase != 0));
    checkOutput("drop_cnt", 32'(dropCnt), mDrop);
    checkOutput("params_flat", paramsFlat, pf);
  end

  task automatic applyStimulus(input logic [7:0] b, input logic r);
    @(negedge clk);
    btn = b;
    rdy = r;
  endtask

  task automatic pulse(input logic [7:0] mask);
    applyStimulus(mask, rdy);
    applyStimulus(8'h00, rdy);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    btn   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for cfg_valid (bounded) and capture the write on the bus
  task automatic waitWrite(output int a, output int d);
    bit seen;
    seen = 1'b0;
    a = -1;
    d = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (cfgIf.cfg_valid) begin
        a = int'(cfgIf.cfg_addr);
        d = int'(cfgIf.cfg_data);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL write_timeout actual=none required=cfg_valid at %0t", $time);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int a, d, seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: single inc, latency three edges after the pulse
    $display("[TB] scenario 1: single increment");
    applyStimulus(8'h00, 1'b1);
    pulse(8'h01);
    @(posedge clk); #1;
    checkOutput("s1_valid_early", 32'(cfgIf.cfg_valid), 0);
    @(posedge clk); #1;
    checkOutput("s1_valid", 32'(cfgIf.cfg_valid), 1);
    checkOutput("s1_addr", 32'(cfgIf.cfg_addr), 0);
    checkOutput("s1_data", 32'(cfgIf.cfg_data), 1);
    @(posedge clk); #1;
    checkOutput("s1_param0", 32'(paramsFlat[7:0]), 1);

    // Scenario 2: three events in one cycle, served in index order
    $display("[TB] scenario 2: three simultaneous events");
    doReset();
    pulse(8'b0010_0101);
    waitWrite(a, d);
    checkOutput("s2_w0_addr", a, 0);
    checkOutput("s2_w0_data", d, 1);
    waitWrite(a, d);
    checkOutput("s2_w1_addr", a, 1);
    checkOutput("s2_w1_data", d, 1);
    waitWrite(a, d);
    checkOutput("s2_w2_addr", a, 2);
    checkOutput("s2_w2_data", d, 0);
    checkOutput("s2_drop", 32'(dropCnt), 0);

    // Scenario 3: back-pressure holds the bus, second pulse on pending bit drops
    $display("[TB] scenario 3: back-pressure");
    doReset();
    applyStimulus(8'h00, 1'b0);
    pulse(8'h01);
    waitWrite(a, d);
    for (int c = 0; c < 10; c++) begin
      applyStimulus((c == 2 || c == 5) ? 8'h01 : 8'h00, 1'b0);
      @(posedge clk); #1;
      checkOutput("s3_hold_valid", 32'(cfgIf.cfg_valid), 1);
      checkOutput("s3_hold_addr", 32'(cfgIf.cfg_addr), 0);
      checkOutput("s3_hold_data", 32'(cfgIf.cfg_data), 1);
    end
    checkOutput("s3_drop", 32'(dropCnt), 1);
    applyStimulus(8'h00, 1'b1);
    @(posedge clk);
    waitWrite(a, d);
    checkOutput("s3_extra_addr", a, 0);
    checkOutput("s3_extra_data", d, 2);

    // Scenario 4: limits on param 3
    $display("[TB] scenario 4: limits");
    doReset();
    applyStimulus(8'h00, 1'b1);
    for (int j = 0; j < PARAM_MAX; j++) begin
      pulse(8'h40);
      waitWrite(a, d);
    end
    checkOutput("s4_param3_max", 32'(paramsFlat[31:24]), PARAM_MAX);
    pulse(8'h40);
    waitWrite(a, d);
    checkOutput("s4_inc_at_max", d, WRAP ? 0 : PARAM_MAX);
    doReset();
    applyStimulus(8'h00, 1'b1);
    pulse(8'h80);
    waitWrite(a, d);
    checkOutput("s4_dec_at_zero_addr", a, 3);
    checkOutput("s4_dec_at_zero", d, WRAP ? PARAM_MAX : 0);

    // Scenario 5: reset while a write is waiting in SEND
    $display("[TB] scenario 5: reset during send");
    doReset();
    applyStimulus(8'h00, 1'b0);
    pulse(8'h04);
    waitWrite(a, d);
    pulse(8'h02);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("s5_valid", 32'(cfgIf.cfg_valid), 0);
    checkOutput("s5_busy", 32'(busy), 0);
    checkOutput("s5_table", paramsFlat, 32'h0);
    checkOutput("s5_drop", 32'(dropCnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (cfgIf.cfg_valid) seen++;
    end
    checkOutput("s5_no_pending", seen, 0);

    // Scenario 6: every bit held pending, grants rotate through all buttons
    $display("[TB] scenario 6: full rotation");
    doReset();
    applyStimulus(8'hFF, 1'b1);
    for (int j = 0; j < 9; j++) begin
      waitWrite(a, d);
      checkOutput("s6_addr", a, (j % 8) / 2);
      checkOutput("s6_data", d, (j % 2 == 0) ? 1 : 0);
    end
    repeat (40) @(posedge clk);
    applyStimulus(8'h00, 1'b1);
    @(posedge clk); #1;
    checkOutput("s6_drop_sat", 32'(dropCnt), 255);

    repeat (8) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
